// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART core.
package uart_pkg;

  // Widest supported data word; narrower words are zero-extended before use.
  localparam int c_max_databits = 9;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Parity bit for a (zero-extended) data word; zero padding does not change the XOR.
  function automatic logic parity_bit(input logic [c_max_databits-1:0] data, input parity_e mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with valid/ready handshakes on both sides.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     push_i,
  output logic                     ready_o,
  output logic [WIDTH-1:0]         data_o,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_level;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_full  = (r_level == (c_aw+1)'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_push  = push_i & ~w_full;
  assign w_pop   = pop_i & ~w_empty;

  assign ready_o = ~w_full;
  assign valid_o = ~w_empty;
  assign data_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;

  // Storage write.
  // NOTE: the storage array has no reset; contents are only observable once the level says so,
  // and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of 2.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_core.sv
// Buffered UART transceiver: TX FIFO -> TX FSM -> pin, pin -> synchroniser -> RX FSM -> RX FIFO.
module uart_buffered_core
  import uart_pkg::*;
#(
  parameter int c_clkfreq    = 100_000_000,
  parameter int c_baudrate   = 10_000_000,
  parameter int c_databits   = 8,
  parameter int c_parity     = 0,
  parameter int c_stopbit    = 1,
  parameter int c_fifo_depth = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [c_databits-1:0]         tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [c_databits-1:0]         rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  input  logic                          rx_i,
  output logic                          tx_o,
  output logic                          tx_active_o,
  output logic                          rx_active_o,
  output logic [$clog2(c_fifo_depth):0] tx_level_o,
  output logic [$clog2(c_fifo_depth):0] rx_level_o,
  output logic                          parity_err_o,
  output logic                          frame_err_o,
  output logic                          overrun_err_o,
  input  logic                          err_clr_i
);

  localparam int c_timerlim = c_clkfreq / c_baudrate;
  localparam int c_tw       = $clog2(2 * c_timerlim);
  localparam int c_bw       = $clog2(c_databits);

  localparam logic [c_tw-1:0] c_bit_last  = c_tw'(c_timerlim - 1);
  localparam logic [c_tw-1:0] c_stop_last = c_tw'(c_stopbit * c_timerlim - 1);
  localparam logic [c_tw-1:0] c_half      = c_tw'(c_timerlim / 2);
  localparam logic [c_bw-1:0] c_bit_top   = c_bw'(c_databits - 1);
  localparam parity_e c_par_mode = (c_parity == 1) ? PAR_EVEN :
                                   (c_parity == 2) ? PAR_ODD  : PAR_NONE;

  if (c_timerlim < 4) begin : g_bad_rate
    $error("uart_buffered_core: c_clkfreq/c_baudrate must be at least 4");
  end
  if (c_databits < 5 || c_databits > c_max_databits) begin : g_bad_width
    $error("uart_buffered_core: c_databits must be 5..9");
  end
  if (c_parity < 0 || c_parity > 2) begin : g_bad_parity
    $error("uart_buffered_core: c_parity must be 0, 1 or 2");
  end
  if (c_stopbit < 1 || c_stopbit > 2) begin : g_bad_stop
    $error("uart_buffered_core: c_stopbit must be 1 or 2");
  end
  if (c_fifo_depth < 2 || (c_fifo_depth & (c_fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("uart_buffered_core: c_fifo_depth must be a power of 2 >= 2");
  end

  // ---------------------------------------------------------------- TX path
  tx_state_e               r_tx_state;
  tx_state_e               w_tx_state_nxt;
  logic [c_tw-1:0]         r_tx_timer;
  logic [c_bw-1:0]         r_tx_bitcnt;
  logic [c_databits-1:0]   r_tx_shift;
  logic                    r_tx_par;
  logic                    r_tx_o;
  logic                    w_tx_tick;
  logic                    w_tx_pop;
  logic                    w_tx_bit;
  logic [c_databits-1:0]   w_txf_data;
  logic                    w_txf_valid;

  uart_sync_fifo #(.WIDTH(c_databits), .DEPTH(c_fifo_depth)) u_tx_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .data_i  (tx_data_i),
    .push_i  (tx_valid_i),
    .ready_o (tx_ready_o),
    .data_o  (w_txf_data),
    .pop_i   (w_tx_pop),
    .valid_o (w_txf_valid),
    .level_o (tx_level_o)
  );

  // TX state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_tx_state <= TX_IDLE;
    else         r_tx_state <= w_tx_state_nxt;
  end

  // TX next state, FIFO pop and line level; STOP may chain straight into START.
  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    w_tx_bit       = 1'b1;
    w_tx_tick      = (r_tx_timer == ((r_tx_state == TX_STOP) ? c_stop_last : c_bit_last));
    case (r_tx_state)
      TX_IDLE: begin
        if (w_txf_valid) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        w_tx_bit = 1'b0;
        if (w_tx_tick) w_tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        w_tx_bit = r_tx_shift[0];
        if (w_tx_tick && r_tx_bitcnt == c_bit_top)
          w_tx_state_nxt = (c_par_mode == PAR_NONE) ? TX_STOP : TX_PARITY;
      end
      TX_PARITY: begin
        w_tx_bit = r_tx_par;
        if (w_tx_tick) w_tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (w_tx_tick) begin
          if (w_txf_valid) begin
            w_tx_pop       = 1'b1;
            w_tx_state_nxt = TX_START;
          end else begin
            w_tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX datapath: bit timer, bit counter, shifter and the registered pin driver.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_timer  <= '0;
      r_tx_bitcnt <= '0;
      r_tx_shift  <= '0;
      r_tx_par    <= 1'b0;
      r_tx_o      <= 1'b1;
    end else begin
      r_tx_o <= w_tx_bit;
      if (r_tx_state == TX_IDLE || w_tx_tick) r_tx_timer <= '0;
      else                                    r_tx_timer <= r_tx_timer + 1'b1;
      if (r_tx_state != TX_DATA) r_tx_bitcnt <= '0;
      else if (w_tx_tick)        r_tx_bitcnt <= r_tx_bitcnt + 1'b1;
      if (w_tx_pop) begin
        r_tx_shift <= w_txf_data;
        r_tx_par   <= parity_bit(c_max_databits'(w_txf_data), c_par_mode);
      end else if (r_tx_state == TX_DATA && w_tx_tick) begin
        r_tx_shift <= r_tx_shift >> 1;
      end
    end
  end

  assign tx_o        = r_tx_o;
  assign tx_active_o = (r_tx_state != TX_IDLE);

  // ---------------------------------------------------------------- RX path
  rx_state_e               r_rx_state;
  rx_state_e               w_rx_state_nxt;
  logic                    r_rx_meta;
  logic                    r_rx_s;
  logic [c_tw-1:0]         r_rx_timer;
  logic [c_bw-1:0]         r_rx_bitcnt;
  logic [c_databits-1:0]   r_rx_shift;
  logic                    r_rx_parbit;
  logic                    r_par_err;
  logic                    r_frame_err;
  logic                    r_overrun_err;
  logic                    w_rx_tick;
  logic                    w_rx_mid;
  logic                    w_rx_push;
  logic                    w_rx_set_par;
  logic                    w_rx_set_frame;
  logic                    w_rx_set_ovr;
  logic                    w_rxf_ready;

  uart_sync_fifo #(.WIDTH(c_databits), .DEPTH(c_fifo_depth)) u_rx_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .data_i  (r_rx_shift),
    .push_i  (w_rx_push),
    .ready_o (w_rxf_ready),
    .data_o  (rx_data_o),
    .pop_i   (rx_ready_i),
    .valid_o (rx_valid_o),
    .level_o (rx_level_o)
  );

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  // RX state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_rx_state <= RX_IDLE;
    else         r_rx_state <= w_rx_state_nxt;
  end

  // RX next state and completion events; start bit is re-checked mid-bit to reject glitches.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_push      = 1'b0;
    w_rx_set_par   = 1'b0;
    w_rx_set_frame = 1'b0;
    w_rx_tick      = (r_rx_timer == c_bit_last);
    w_rx_mid       = (r_rx_timer == c_half);
    case (r_rx_state)
      RX_IDLE: if (!r_rx_s) w_rx_state_nxt = RX_START;
      RX_START: begin
        if (w_rx_mid) w_rx_state_nxt = r_rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (w_rx_tick && r_rx_bitcnt == c_bit_top)
          w_rx_state_nxt = (c_par_mode == PAR_NONE) ? RX_STOP : RX_PARITY;
      end
      RX_PARITY: if (w_rx_tick) w_rx_state_nxt = RX_STOP;
      RX_STOP: begin
        if (w_rx_tick) begin
          if (r_rx_s) begin
            w_rx_push      = 1'b1;
            w_rx_set_par   = (c_par_mode != PAR_NONE) &&
                             (r_rx_parbit != parity_bit(c_max_databits'(r_rx_shift), c_par_mode));
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_set_frame = 1'b1;
            w_rx_state_nxt = RX_BREAK;
          end
        end
      end
      RX_BREAK: if (r_rx_s) w_rx_state_nxt = RX_IDLE;
      default:  w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign w_rx_set_ovr = w_rx_push & ~w_rxf_ready;

  // RX datapath: timer restarts at the start-bit midpoint so later samples land mid-bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rx_timer  <= '0;
      r_rx_bitcnt <= '0;
      r_rx_shift  <= '0;
      r_rx_parbit <= 1'b0;
    end else begin
      if (r_rx_state == RX_IDLE || r_rx_state == RX_BREAK || w_rx_tick ||
          (r_rx_state == RX_START && w_rx_mid))
        r_rx_timer <= '0;
      else
        r_rx_timer <= r_rx_timer + 1'b1;
      if (r_rx_state != RX_DATA) r_rx_bitcnt <= '0;
      else if (w_rx_tick)        r_rx_bitcnt <= r_rx_bitcnt + 1'b1;
      if (r_rx_state == RX_DATA && w_rx_tick)
        r_rx_shift <= {r_rx_s, r_rx_shift[c_databits-1:1]};
      if (r_rx_state == RX_PARITY && w_rx_tick)
        r_rx_parbit <= r_rx_s;
    end
  end

  // Sticky error flags; a new error in the same cycle wins over a clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_par_err     <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      if (w_rx_set_par)        r_par_err     <= 1'b1;
      else if (err_clr_i)      r_par_err     <= 1'b0;
      if (w_rx_set_frame)      r_frame_err   <= 1'b1;
      else if (err_clr_i)      r_frame_err   <= 1'b0;
      if (w_rx_set_ovr)        r_overrun_err <= 1'b1;
      else if (err_clr_i)      r_overrun_err <= 1'b0;
    end
  end

  assign parity_err_o  = r_par_err;
  assign frame_err_o   = r_frame_err;
  assign overrun_err_o = r_overrun_err;
  assign rx_active_o   = (r_rx_state != RX_IDLE);

endmodule

// File: tb/tb_uart_buffered_core.sv
// Randomised bench for uart_buffered_core: three instances (8N1, 8E2, 8O1), each looped back
// or driven from a bench-side line model; expected line bits come from a frame-format model.
module tb_uart_buffered_core;

  localparam int T = 10;          // clocks per bit
  localparam int D = 16;          // FIFO depth

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data [3];
  logic [2:0] tx_valid = '0;
  logic [2:0] rx_ready = '0;
  logic [2:0] err_clr  = '0;
  logic [2:0] loop_en  = '1;
  logic [2:0] drv      = '1;

  wire  [2:0] tx_ready, rx_valid, tx_o, rx_in, tx_active, rx_active, par_err, frm_err, ovr_err;
  wire  [7:0] rx_data  [3];
  wire  [4:0] tx_level [3];
  wire  [4:0] rx_level [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rx_in[g] = loop_en[g] ? tx_o[g] : drv[g];
    uart_buffered_core #(.c_parity(g), .c_stopbit((g == 1) ? 2 : 1), .c_fifo_depth(D)) u_dut (
      .clk_i         (clk),
      .rstn_i        (rstn),
      .tx_data_i     (tx_data[g]),
      .tx_valid_i    (tx_valid[g]),
      .tx_ready_o    (tx_ready[g]),
      .rx_data_o     (rx_data[g]),
      .rx_valid_o    (rx_valid[g]),
      .rx_ready_i    (rx_ready[g]),
      .rx_i          (rx_in[g]),
      .tx_o          (tx_o[g]),
      .tx_active_o   (tx_active[g]),
      .rx_active_o   (rx_active[g]),
      .tx_level_o    (tx_level[g]),
      .rx_level_o    (rx_level[g]),
      .parity_err_o  (par_err[g]),
      .frame_err_o   (frm_err[g]),
      .overrun_err_o (ovr_err[g]),
      .err_clr_i     (err_clr[g])
    );
  end

  // Span of TX activity on instance 0, used to prove back-to-back frames.
  logic mon_clr = 1'b0;
  int   cyc = 0, first_act = -1, last_act = -1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      first_act <= -1;
      last_act  <= -1;
    end else if (tx_active[0]) begin
      if (first_act < 0) first_act <= cyc;
      last_act <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame model: instance idx uses parity mode idx (0 none, 1 even, 2 odd) and 2 stop bits for idx 1.
  function automatic int frame_bits(input int idx, input logic [7:0] d, output logic [11:0] bits);
    int n;
    int ones;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n    = 9;
    ones = $countones(d);
    if (idx == 1) begin bits[n] = (ones % 2 == 1); n++; end
    if (idx == 2) begin bits[n] = (ones % 2 == 0); n++; end
    return n + ((idx == 1) ? 2 : 1);
  endfunction

  task automatic push(input int idx, input logic [7:0] d, output int waited);
    @(negedge clk);
    tx_data[idx]  = d;
    tx_valid[idx] = 1'b1;
    waited = 0;
    while (!tx_ready[idx] && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 3000) check("push_timeout", 32'(tx_ready[idx]), 1);
    @(posedge clk);
    #1 tx_valid[idx] = 1'b0;
  endtask

  task automatic pop_expect(input int idx, input logic [7:0] exp, input string tag);
    int k = 0;
    @(negedge clk);
    while (!rx_valid[idx] && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(rx_valid[idx]), 1);
    check({tag, "_data"}, 32'(rx_data[idx]), 32'(exp));
    rx_ready[idx] = 1'b1;
    @(posedge clk);
    #1 rx_ready[idx] = 1'b0;
  endtask

  task automatic clear_err(input int idx);
    @(negedge clk);
    err_clr[idx] = 1'b1;
    @(posedge clk);
    #1 err_clr[idx] = 1'b0;
  endtask

  task automatic wait_tx_idle(input int idx);
    int k = 0;
    @(negedge clk);
    while ((tx_active[idx] || tx_level[idx] != 0) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("tx%0d_idle_in_time", idx), 32'(k < 4000), 1);
    repeat (4 * T) @(negedge clk);
  endtask

  // Push one word and compare the pin against the frame model at every bit centre.
  task automatic tx_wave(input int idx, input logic [7:0] d);
    logic [11:0] bits;
    int nb, w;
    nb = frame_bits(idx, d, bits);
    push(idx, d, w);
    for (int n = 1; n <= 2 + T * (nb - 1) + T / 2; n++) begin
      @(posedge clk);
      #1;
      if (n == 1)      check($sformatf("tx%0d_hold", idx), 32'(tx_o[idx]), 1);
      else if (n == 2) check($sformatf("tx%0d_fall", idx), 32'(tx_o[idx]), 0);
      else if ((n - 2) % T == T / 2)
        check($sformatf("tx%0d_bit%0d", idx, (n - 2) / T), 32'(tx_o[idx]), 32'(bits[(n - 2) / T]));
    end
  endtask

  // Drive a frame onto the RX pin, optionally with a wrong parity bit or a low stop bit.
  task automatic drive_frame(input int idx, input logic [7:0] d, input bit flip_par, input bit bad_stop);
    logic [11:0] bits;
    int nb;
    nb = frame_bits(idx, d, bits);
    if (flip_par) bits[9] = ~bits[9];
    if (bad_stop) bits[(idx == 0) ? 9 : 10] = 1'b0;
    @(negedge clk);
    loop_en[idx] = 1'b0;
    for (int b = 0; b < nb; b++) begin
      drv[idx] = bits[b];
      repeat (T) @(negedge clk);
    end
    drv[idx] = 1'b1;
    repeat (3 * T) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    logic [7:0] words [$];
    logic [7:0] d;
    int w;

    for (int g = 0; g < 3; g++) tx_data[g] = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst%0d_tx_o", g), 32'(tx_o[g]), 1);
      check($sformatf("rst%0d_tx_ready", g), 32'(tx_ready[g]), 1);
      check($sformatf("rst%0d_rx_valid", g), 32'(rx_valid[g]), 0);
      check($sformatf("rst%0d_levels", g), {tx_level[g], rx_level[g]}, 0);
      check($sformatf("rst%0d_errs", g), {par_err[g], frm_err[g], ovr_err[g]}, 0);
      check($sformatf("rst%0d_active", g), {tx_active[g], rx_active[g]}, 0);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 on every format, checked on the pin and after loopback.
    for (int g = 0; g < 3; g++) begin
      tx_wave(g, 8'hA5);
      pop_expect(g, 8'hA5, $sformatf("lb%0d_a5", g));
      check($sformatf("lb%0d_par_err", g), 32'(par_err[g]), 0);
    end

    // Random loopback bursts.
    for (int g = 0; g < 3; g++) begin
      words.delete();
      for (int i = 0; i < 6; i++) begin
        d = 8'($urandom);
        words.push_back(d);
        push(g, d, w);
      end
      wait_tx_idle(g);
      check($sformatf("rnd%0d_rx_level", g), 32'(rx_level[g]), 6);
      for (int i = 0; i < 6; i++) pop_expect(g, words[i], $sformatf("rnd%0d_w%0d", g, i));
      check($sformatf("rnd%0d_errs", g), {par_err[g], frm_err[g], ovr_err[g]}, 0);
    end

    // Fill TX FIFO, stream 18 frames back-to-back into an RX FIFO that is never popped.
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    words.delete();
    for (int i = 0; i < 18; i++) begin
      d = 8'($urandom);
      words.push_back(d);
      push(0, d, w);
      if (i == 16) begin
        check("full_tx_level", 32'(tx_level[0]), D);
        check("full_tx_ready", 32'(tx_ready[0]), 0);
      end
      if (i == 17) check("full_18th_waited", 32'(w > 0), 1);
    end
    wait_tx_idle(0);
    check("b2b_span", 32'(last_act - first_act + 1), 18 * 10 * T);
    check("ovr_rx_level", 32'(rx_level[0]), D);
    check("ovr_flag", 32'(ovr_err[0]), 1);
    check("ovr_other_errs", {par_err[0], frm_err[0]}, 0);
    for (int i = 0; i < D; i++) pop_expect(0, words[i], $sformatf("ovr_w%0d", i));
    check("ovr_drained", 32'(rx_level[0]), 0);
    clear_err(0);
    check("ovr_cleared", 32'(ovr_err[0]), 0);

    // Corrupted parity: flag set, word still delivered.
    for (int g = 1; g < 3; g++) begin
      d = 8'($urandom);
      drive_frame(g, d, 1'b1, 1'b0);
      check($sformatf("perr%0d_flag", g), 32'(par_err[g]), 1);
      check($sformatf("perr%0d_level", g), 32'(rx_level[g]), 1);
      pop_expect(g, d, $sformatf("perr%0d", g));
      clear_err(g);
      check($sformatf("perr%0d_cleared", g), 32'(par_err[g]), 0);
      d = 8'($urandom);
      drive_frame(g, d, 1'b0, 1'b0);
      pop_expect(g, d, $sformatf("pok%0d", g));
      check($sformatf("pok%0d_flag", g), 32'(par_err[g]), 0);
    end

    // Framing error: nothing pushed, break exits once the line is high, next frame is clean.
    drive_frame(0, 8'($urandom), 1'b0, 1'b1);
    check("ferr_flag", 32'(frm_err[0]), 1);
    check("ferr_level", 32'(rx_level[0]), 0);
    check("ferr_rx_idle", 32'(rx_active[0]), 0);
    d = 8'($urandom);
    drive_frame(0, d, 1'b0, 1'b0);
    pop_expect(0, d, "after_break");
    clear_err(0);
    check("ferr_cleared", 32'(frm_err[0]), 0);

    // Short low glitch: no word, no flags.
    @(negedge clk);
    drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    drv[0] = 1'b1;
    repeat (3 * T) @(negedge clk);
    check("glitch_rx_idle", 32'(rx_active[0]), 0);
    check("glitch_level", 32'(rx_level[0]), 0);
    check("glitch_errs", {par_err[0], frm_err[0], ovr_err[0]}, 0);

    // Reset during DATA with a sticky flag set.
    drive_frame(0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    loop_en[0] = 1'b1;
    push(0, 8'h00, w);
    repeat (35) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx_o[0]), 0);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_tx_o", 32'(tx_o[0]), 1);
    check("rst_mid_levels", {tx_level[0], rx_level[0]}, 0);
    check("rst_mid_errs", {par_err[0], frm_err[0], ovr_err[0]}, 0);
    check("rst_mid_active", {tx_active[0], rx_active[0]}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    tx_wave(0, 8'h3C);
    pop_expect(0, 8'h3C, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
